imc_cmd_sequencer: RTL and testbench
====================================

// Module: imc_cmd_sequencer
// PURPOSE
// Upstream command stage for the PRIME IMC datapath. Buffers host read/write commands and
// replays them in order as an Avalon-MM master onto the datapath's IMC_mm slave, honouring
// waitrequest. Pipelined read responses (readdatavalid) are collected into a response FIFO.
// A credit limit guarantees that no returning read data is ever dropped.
// PARAMETERS
// CMD_DEPTH        16  command FIFO entries (power of 2, >=2)
// RSP_DEPTH        16  response FIFO entries (power of 2, >=MAX_OUTSTANDING)
// MAX_OUTSTANDING  4   max reads accepted by the slave but not yet returned (>=1)
// IMC_ADDR_BITS    9   IMC slave word-address width
// PORTS
// sys_clk_in            in   1   system clock; all logic on rising edge
// sys_reset_in          in   1   asynchronous, active-low reset
// cmd_valid_in          in   1   command offered
// cmd_ready_out         out  1   command FIFO not full; transfer = valid & ready
// cmd_write_in          in   1   1 = write, 0 = read
// cmd_addr_in           in   IMC_ADDR_BITS  target address
// cmd_data_in           in   32  write data (ignored for reads)
// rsp_valid_out         out  1   response FIFO not empty
// rsp_ready_in          in   1   response pop; transfer = valid & ready
// rsp_data_out          out  32  head read data (first-word fall-through)
// IMC_mm_address_out    out  IMC_ADDR_BITS  master address
// IMC_mm_writedata_out  out  32  master write data
// IMC_mm_write_out      out  1   master write strobe
// IMC_mm_read_out       out  1   master read strobe
// IMC_mm_waitrequest_in in   1   slave stall
// IMC_mm_readdata_in    in   32  slave read data
// IMC_mm_readdatavalid_in in 1   slave read data valid
// busy_out              out  1   commands queued, bus request pending, or reads outstanding
// err_spurious_rdv_out  out  1   sticky: readdatavalid seen with zero outstanding reads
// err_clear_in          in   1   synchronous clear of the sticky error
// BEHAVIOUR
// - Reset (sys_reset_in=0): FIFOs empty, counters 0, FSM IDLE.
//   All outputs 0 except cmd_ready_out=1. Reset mid-transfer abandons the in-flight command.
// - IMC_mm_* outputs are registered. A command accepted in cycle N reaches the bus at N+1 at
//   the earliest (with an empty FIFO and credit available).
// - FSM IDLE: when the cmd FIFO is non-empty and the head is issuable, pop it, load the bus
//   registers, and go to REQ.
//   Head is issuable if it is a write, or if it is a read with outstanding < MAX_OUTSTANDING
//   and outstanding + rsp_count < RSP_DEPTH.
// - FSM REQ: hold address, data and strobe stable while waitrequest=1.
//   When waitrequest=0 the transfer completes. If the next head is issuable, reload and stay
//   in REQ (back-to-back, one transfer per cycle). Otherwise drop the strobe and go to IDLE.
// - Exactly one of write_out / read_out is high in REQ; both are 0 in IDLE. Commands are
//   issued strictly in FIFO order; a blocked read also blocks any writes behind it.
// - outstanding counter: +1 on read & !waitrequest, -1 on readdatavalid, unchanged when both
//   occur in the same cycle. Range 0..MAX_OUTSTANDING.
// - readdatavalid with outstanding=0: data is dropped and err_spurious_rdv_out is set.
//   The error stays set until err_clear_in; a set in the same cycle as a clear wins.
// - The response FIFO pushes readdata_in on every valid readdatavalid. Push and pop in the
//   same cycle are legal, including when the FIFO is full. Credits make overflow impossible.
// - Simultaneous command push and pop are legal when the cmd FIFO is full; cmd_ready_out
//   reflects the registered full flag only.
// - FIFO pointers are log2(DEPTH)+1 bits and wrap naturally; the extra MSB distinguishes
//   full from empty.
// - busy_out = cmd_count!=0 | state==REQ | outstanding!=0. It is combinational from
//   registered state.
// STRUCTURE
// - imc_seq_pkg: typedef struct packed {logic write; logic [IMC_ADDR_BITS-1:0] addr;
//   logic [31:0] data;} imc_cmd_t; typedef enum logic {IDLE, REQ} seq_state_t;
//   localparam IMC_DATA_W = 32.
// - Sub-module sync_fifo #(WIDTH, DEPTH): FWFT, count output. Instantiated twice
//   (imc_cmd_t and 32-bit response).
// - Top level: FSM, outstanding/credit counter, error flag.
// TESTING
// 1. Write A=0x05 D=0xDEADBEEF, waitrequest=0 -> write_out=1 for exactly one cycle,
//    starting the cycle after acceptance, with addr 0x05 and data 0xDEADBEEF.
// 2. Read 0x10 with waitrequest=1 for 3 cycles -> read_out and address held 4 cycles.
//    Readdatavalid 0x1234 two cycles later -> rsp_data_out=0x1234, outstanding returns to 0.
// 3. Six reads back-to-back, slave never returns data -> exactly 4 strobes accepted,
//    then read_out=0 and busy_out=1.
//    Return one rdv -> the 5th read issues.
// 4. rsp_ready_in=0, 16 reads completed -> the 17th read is withheld until one pop.
//    No data is lost.
// 5. readdatavalid with nothing outstanding -> err_spurious_rdv_out=1 and no response pushed.
//    err_clear_in=1 -> flag is 0 next cycle.
// 6. Assert reset during REQ with 3 queued commands -> all strobes 0 immediately,
//    cmd_ready_out=1, busy_out=0.
//    Post-reset commands execute normally.

Source files
------------

// File: rtl/imc_seq_pkg.sv
// Shared types for the IMC command sequencer.
// Command bundle, FSM states and bus widths.
package imc_seq_pkg;

  localparam int IMC_DATA_W = 32;
  localparam int IMC_ADDR_W = 9;

  typedef struct packed {
    logic                  write;
    logic [IMC_ADDR_W-1:0] addr;
    logic [IMC_DATA_W-1:0] data;
  } imc_cmd_t;

  typedef enum logic {
    IDLE,
    REQ
  } seq_state_t;

endpackage

// File: rtl/imc_cmd_sequencer_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count = wptr_q - rptr_q;
  assign dout  = mem[rptr_q[AW-1:0]];

  // a pop frees the slot, so push-while-full is fine when popping
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/imc_cmd_sequencer.sv
// Buffers host commands and replays them as an Avalon-MM master,
// collecting pipelined read data under a credit limit.
module imc_cmd_sequencer
  import imc_seq_pkg::*;
#(
  parameter int CMD_DEPTH       = 16,
  parameter int RSP_DEPTH       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int IMC_ADDR_BITS   = IMC_ADDR_W
) (
  input  logic                     sys_clk_in,
  input  logic                     sys_reset_in,
  input  logic                     cmd_valid_in,
  output logic                     cmd_ready_out,
  input  logic                     cmd_write_in,
  input  logic [IMC_ADDR_BITS-1:0] cmd_addr_in,
  input  logic [IMC_DATA_W-1:0]    cmd_data_in,
  output logic                     rsp_valid_out,
  input  logic                     rsp_ready_in,
  output logic [IMC_DATA_W-1:0]    rsp_data_out,
  output logic [IMC_ADDR_BITS-1:0] IMC_mm_address_out,
  output logic [IMC_DATA_W-1:0]    IMC_mm_writedata_out,
  output logic                     IMC_mm_write_out,
  output logic                     IMC_mm_read_out,
  input  logic                     IMC_mm_waitrequest_in,
  input  logic [IMC_DATA_W-1:0]    IMC_mm_readdata_in,
  input  logic                     IMC_mm_readdatavalid_in,
  output logic                     busy_out,
  output logic                     err_spurious_rdv_out,
  input  logic                     err_clear_in
);

  localparam int CW  = $clog2(CMD_DEPTH) + 1;
  localparam int RW  = $clog2(RSP_DEPTH) + 1;
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int CRW = $clog2(RSP_DEPTH + MAX_OUTSTANDING + 2) + 1;

  imc_cmd_t             cmd_in;
  imc_cmd_t             head;
  logic                 cmd_push;
  logic                 cmd_pop;
  logic                 cmd_full;
  logic                 cmd_empty;
  logic [CW-1:0]        cmd_count;

  logic                 rsp_push;
  logic                 rsp_full;
  logic                 rsp_empty;
  logic [RW-1:0]        rsp_count;
  logic [IMC_DATA_W-1:0] rsp_dout;

  seq_state_t               state_q, state_d;
  logic [IMC_ADDR_BITS-1:0] addr_q, addr_d;
  logic [IMC_DATA_W-1:0]    wdata_q, wdata_d;
  logic                     wr_q, wr_d;
  logic                     rd_q, rd_d;
  logic [OW-1:0]            outst_q, outst_d;
  logic                     err_q, err_d;

  logic                 rd_acc;
  logic                 rdv_ok;
  logic                 rdv_bad;
  logic [CRW-1:0]       outst_eff;
  logic [CRW-1:0]       rsp_used;
  logic                 credit_ok;
  logic                 head_ok;

  always_comb begin
    cmd_in       = '0;
    cmd_in.write = cmd_write_in;
    cmd_in.addr  = IMC_ADDR_W'(cmd_addr_in);
    cmd_in.data  = cmd_data_in;
  end

  assign cmd_ready_out = ~cmd_full;
  assign cmd_push      = cmd_valid_in & ~cmd_full;

  sync_fifo #(
    .WIDTH ($bits(imc_cmd_t)),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk   (sys_clk_in),
    .rst_n (sys_reset_in),
    .push  (cmd_push),
    .din   (cmd_in),
    .pop   (cmd_pop),
    .dout  (head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  sync_fifo #(
    .WIDTH (IMC_DATA_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (sys_clk_in),
    .rst_n (sys_reset_in),
    .push  (rsp_push),
    .din   (IMC_mm_readdata_in),
    .pop   (rsp_ready_in),
    .dout  (rsp_dout),
    .full  (rsp_full),
    .empty (rsp_empty),
    .count (rsp_count)
  );

  assign rsp_valid_out = ~rsp_empty;
  assign rsp_data_out  = rsp_empty ? '0 : rsp_dout;

  assign rd_acc  = (state_q == REQ) & rd_q & ~IMC_mm_waitrequest_in;
  assign rdv_ok  = IMC_mm_readdatavalid_in & (outst_q != '0);
  assign rdv_bad = IMC_mm_readdatavalid_in & (outst_q == '0);
  assign rsp_push = rdv_ok;

  // count the read finishing this cycle so a back-to-back reload
  // never overruns the outstanding or response-slot budget
  assign outst_eff = CRW'(outst_q) + CRW'(rd_acc);
  assign rsp_used  = outst_eff + CRW'(rsp_count);
  assign credit_ok = (outst_eff < CRW'(MAX_OUTSTANDING)) &&
                     (rsp_used < CRW'(RSP_DEPTH)) && ~rsp_full;
  assign head_ok   = ~cmd_empty & (head.write | credit_ok);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cmd_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (head_ok) begin
          cmd_pop = 1'b1;
          addr_d  = IMC_ADDR_BITS'(head.addr);
          wdata_d = head.data;
          wr_d    = head.write;
          rd_d    = ~head.write;
          state_d = REQ;
        end
      end
      REQ: begin
        if (!IMC_mm_waitrequest_in) begin
          if (head_ok) begin
            cmd_pop = 1'b1;
            addr_d  = IMC_ADDR_BITS'(head.addr);
            wdata_d = head.data;
            wr_d    = head.write;
            rd_d    = ~head.write;
          end else begin
            wr_d    = 1'b0;
            rd_d    = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    outst_d = outst_q + OW'(rd_acc) - OW'(rdv_ok);
    err_d   = err_q;
    if (err_clear_in) err_d = 1'b0;
    if (rdv_bad)      err_d = 1'b1;
  end

  always_ff @(posedge sys_clk_in or negedge sys_reset_in) begin
    if (!sys_reset_in) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      outst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      outst_q <= outst_d;
      err_q   <= err_d;
    end
  end

  assign IMC_mm_address_out   = addr_q;
  assign IMC_mm_writedata_out = wdata_q;
  assign IMC_mm_write_out     = wr_q;
  assign IMC_mm_read_out      = rd_q;
  assign err_spurious_rdv_out = err_q;
  assign busy_out = (cmd_count != '0) | (state_q == REQ) |
                    (outst_q != '0);

endmodule

// File: tb/tb_imc_cmd_sequencer.sv
// Directed bench for the IMC command sequencer.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_imc_cmd_sequencer;
  import imc_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [8:0]  cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [8:0]  mm_addr;
  logic [31:0] mm_wdata;
  logic        mm_wr;
  logic        mm_rd;
  logic        waitreq = 1'b0;
  logic [31:0] rdata = '0;
  logic        rdv = 1'b0;
  logic        busy;
  logic        err;
  logic        err_clear = 1'b0;

  int total = 0;
  int bad = 0;

  imc_cmd_t    cmd_q[$];
  logic [8:0]  pend_q[$];
  logic [31:0] exp_rsp[$];
  bit          auto_rdv = 1'b0;
  int          acc_rd = 0;

  always #5 clk = ~clk;

  imc_cmd_sequencer dut (
    .sys_clk_in              (clk),
    .sys_reset_in            (rst_n),
    .cmd_valid_in            (cmd_valid),
    .cmd_ready_out           (cmd_ready),
    .cmd_write_in            (cmd_write),
    .cmd_addr_in             (cmd_addr),
    .cmd_data_in             (cmd_data),
    .rsp_valid_out           (rsp_valid),
    .rsp_ready_in            (rsp_ready),
    .rsp_data_out            (rsp_data),
    .IMC_mm_address_out      (mm_addr),
    .IMC_mm_writedata_out    (mm_wdata),
    .IMC_mm_write_out        (mm_wr),
    .IMC_mm_read_out         (mm_rd),
    .IMC_mm_waitrequest_in   (waitreq),
    .IMC_mm_readdata_in      (rdata),
    .IMC_mm_readdatavalid_in (rdv),
    .busy_out                (busy),
    .err_spurious_rdv_out    (err),
    .err_clear_in            (err_clear)
  );

  // one cycle of host feeder plus in-order slave returning one read per cycle
  task automatic step();
    imc_cmd_t   c;
    logic [8:0] a;
    @(negedge clk);
    rdv = 1'b0;
    if (auto_rdv && pend_q.size() != 0) begin
      a = pend_q.pop_front();
      rdv = 1'b1;
      rdata = 32'hC0DE_0000 | 32'(a);
      exp_rsp.push_back(rdata);
    end
    if (mm_rd && !waitreq) begin
      pend_q.push_back(mm_addr);
      acc_rd++;
    end
    if (cmd_q.size() != 0) begin
      c = cmd_q[0];
      cmd_valid = 1'b1;
      cmd_write = c.write;
      cmd_addr  = c.addr;
      cmd_data  = c.data;
      if (cmd_ready) cmd_q.delete(0);
    end else begin
      cmd_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({mm_wr, mm_rd, busy, err, rsp_valid} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 00000",
               {mm_wr, mm_rd, busy, err, rsp_valid});
    end
    total++;
    if (cmd_ready !== 1'b1 || mm_addr !== 9'h0 || mm_wdata !== 32'h0 ||
        rsp_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_data: rdy=%b addr=%h wd=%h rd=%h want 1/0/0/0",
               cmd_ready, mm_addr, mm_wdata, rsp_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 9'h05;
    cmd_data  = 32'hDEADBEEF;
    @(negedge clk);
    cmd_valid = 1'b0;
    total++;
    if (mm_wr !== 1'b0) begin
      bad++;
      $display("FAIL wr_early: got %b want 0", mm_wr);
    end
    @(negedge clk);
    total++;
    if (mm_wr !== 1'b1 || mm_rd !== 1'b0 || mm_addr !== 9'h05 ||
        mm_wdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL wr_bus: got wr=%b rd=%b a=%h d=%h want 1 0 005 deadbeef",
               mm_wr, mm_rd, mm_addr, mm_wdata);
    end
    @(negedge clk);
    total++;
    if (mm_wr !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL wr_end: got wr=%b busy=%b want 0 0", mm_wr, busy);
    end
  endtask

  task automatic test_read_wait();
    int held;
    held = 0;
    waitreq   = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 9'h10;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mm_rd && mm_addr == 9'h10) held++;
      if (i == 3) waitreq = 1'b0;
    end
    total++;
    if (held != 4) begin
      bad++;
      $display("FAIL rd_hold: got %0d cycles want 4", held);
    end
    total++;
    if (mm_rd !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rd_wait_out: got rd=%b busy=%b want 0 1", mm_rd, busy);
    end
    @(negedge clk);
    rdv   = 1'b1;
    rdata = 32'h1234;
    @(negedge clk);
    rdv = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h1234 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rd_rsp: got v=%b d=%h busy=%b want 1 00001234 0",
               rsp_valid, rsp_data, busy);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rd_pop: got v=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_credit_limit();
    int acc0;
    int n;
    imc_cmd_t c;
    acc0 = acc_rd;
    for (int i = 0; i < 6; i++) begin
      c = '0;
      c.addr = 9'h20 + 9'(i);
      cmd_q.push_back(c);
    end
    repeat (15) step();
    total++;
    if (acc_rd - acc0 != 4) begin
      bad++;
      $display("FAIL credit_cap: got %0d reads want 4", acc_rd - acc0);
    end
    total++;
    if (mm_rd !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL credit_stall: got rd=%b busy=%b want 0 1", mm_rd, busy);
    end
    auto_rdv = 1'b1;
    step();
    auto_rdv = 1'b0;
    repeat (6) step();
    total++;
    if (acc_rd - acc0 != 5) begin
      bad++;
      $display("FAIL credit_fifth: got %0d reads want 5", acc_rd - acc0);
    end
    auto_rdv  = 1'b1;
    rsp_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid) begin
        n++;
        total++;
        if (exp_rsp.size() == 0 || rsp_data !== exp_rsp[0]) begin
          bad++;
          $display("FAIL credit_data: got %h want %h", rsp_data,
                   exp_rsp.size() != 0 ? exp_rsp[0] : 32'hx);
        end
        if (exp_rsp.size() != 0) exp_rsp.delete(0);
      end
      step();
    end
    rsp_ready = 1'b0;
    total++;
    if (n != 6 || busy !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL credit_drain: got n=%0d busy=%b err=%b want 6 0 0",
               n, busy, err);
    end
  endtask

  task automatic test_rsp_credit();
    int acc0;
    int n;
    imc_cmd_t c;
    acc0 = acc_rd;
    for (int i = 0; i < 17; i++) begin
      c = '0;
      c.addr = 9'h40 + 9'(i);
      cmd_q.push_back(c);
    end
    auto_rdv  = 1'b1;
    rsp_ready = 1'b0;
    repeat (70) step();
    total++;
    if (acc_rd - acc0 != 16) begin
      bad++;
      $display("FAIL rsp_cap: got %0d reads want 16", acc_rd - acc0);
    end
    total++;
    if (mm_rd !== 1'b0 || rsp_valid !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rsp_stall: got rd=%b v=%b busy=%b want 0 1 1",
               mm_rd, rsp_valid, busy);
    end
    rsp_ready = 1'b1;
    total++;
    if (rsp_data !== 32'hC0DE_0040) begin
      bad++;
      $display("FAIL rsp_first: got %h want c0de0040", rsp_data);
    end
    if (exp_rsp.size() != 0) exp_rsp.delete(0);
    step();
    rsp_ready = 1'b0;
    repeat (8) step();
    total++;
    if (acc_rd - acc0 != 17) begin
      bad++;
      $display("FAIL rsp_17th: got %0d reads want 17", acc_rd - acc0);
    end
    rsp_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) begin
        n++;
        total++;
        if (exp_rsp.size() == 0 || rsp_data !== exp_rsp[0]) begin
          bad++;
          $display("FAIL rsp_data: got %h want %h", rsp_data,
                   exp_rsp.size() != 0 ? exp_rsp[0] : 32'hx);
        end
        if (exp_rsp.size() != 0) exp_rsp.delete(0);
      end
      step();
    end
    rsp_ready = 1'b0;
    auto_rdv  = 1'b0;
    total++;
    if (n != 16 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rsp_drain: got n=%0d busy=%b v=%b want 16 0 0",
               n, busy, rsp_valid);
    end
  endtask

  task automatic test_spurious();
    @(negedge clk);
    rdv   = 1'b1;
    rdata = 32'hBAD0BAD0;
    @(negedge clk);
    rdv = 1'b0;
    total++;
    if (err !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL spur_set: got err=%b v=%b want 1 0", err, rsp_valid);
    end
    rdv       = 1'b1;
    err_clear = 1'b1;
    @(negedge clk);
    rdv       = 1'b0;
    err_clear = 1'b0;
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL spur_set_wins: got %b want 1", err);
    end
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL spur_clear: got %b want 0", err);
    end
  endtask

  task automatic test_reset_mid();
    waitreq = 1'b1;
    cmd_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd_addr  = 9'h60 + 9'(i);
      cmd_data  = 32'h1000 + 32'(i);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    total++;
    if (mm_wr !== 1'b1 || mm_addr !== 9'h60 || busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_req: got wr=%b a=%h busy=%b want 1 060 1",
               mm_wr, mm_addr, busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (mm_wr !== 1'b0 || mm_rd !== 1'b0 || cmd_ready !== 1'b1 ||
        busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got wr=%b rd=%b rdy=%b busy=%b want 0 0 1 0",
               mm_wr, mm_rd, cmd_ready, busy);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    waitreq   = 1'b0;
    cmd_valid = 1'b1;
    cmd_addr  = 9'h1AB;
    cmd_data  = 32'hCAFEF00D;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    total++;
    if (mm_wr !== 1'b1 || mm_addr !== 9'h1AB || mm_wdata !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL post_reset_wr: got wr=%b a=%h d=%h want 1 1ab cafef00d",
               mm_wr, mm_addr, mm_wdata);
    end
    @(negedge clk);
    total++;
    if (mm_wr !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: got wr=%b busy=%b want 0 0", mm_wr, busy);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_credit_limit();
    test_rsp_credit();
    test_spurious();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
